// File: rtl/i8253_readback.sv
// Read side of one i8253 counter channel: latch command, LSB/MSB byte
// sequencing and the registered CPU read byte.
module i8253_readback #(
    parameter logic [1:0] COUNTER_ID = 2'd0
) (
    input  logic        clk21m,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        rd,
    input  logic [1:0]  a,
    input  logic        wr_cw,
    input  logic [7:0]  wr_d,
    input  logic [15:0] counter,
    output logic [7:0]  q,
    output logic        q_update
);

    logic [1:0]  rw_q, rw_d;
    logic        msb_next_q, msb_next_d;
    logic        latched_q, latched_d;
    logic [15:0] latch_q, latch_d;
    logic [7:0]  q_q, q_d;
    logic        q_update_q, q_update_d;
    logic        rd_dly_q;

    logic        rd_hit, rd_rise, cw_hit;
    logic [15:0] src;
    logic        cw_unused;

    assign rd_hit    = cs & rd & (a == COUNTER_ID);
    assign rd_rise   = rd_hit & ~rd_dly_q;
    assign src       = latched_q ? latch_q : counter;
    assign cw_hit    = wr_cw & (wr_d[7:6] == COUNTER_ID) & (wr_d[7:6] != 2'b11);
    assign cw_unused = ^wr_d[3:0];

    always_comb begin
        rw_d       = rw_q;
        msb_next_d = msb_next_q;
        latched_d  = latched_q;
        latch_d    = latch_q;
        q_d        = q_q;
        q_update_d = rd_rise;

        // Read is resolved first from the pre-cycle state.
        if (rd_rise) begin
            case (rw_q)
                2'b01: begin
                    q_d       = src[7:0];
                    latched_d = 1'b0;
                end
                2'b10: begin
                    q_d       = src[15:8];
                    latched_d = 1'b0;
                end
                2'b11: begin
                    if (!msb_next_q) begin
                        q_d        = src[7:0];
                        msb_next_d = 1'b1;
                    end else begin
                        q_d        = src[15:8];
                        msb_next_d = 1'b0;
                        latched_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // A same-cycle control word overrides the read's effects; a latch
        // command may re-arm a latch that this very read just released.
        if (cw_hit) begin
            if (wr_d[5:4] != 2'b00) begin
                rw_d       = wr_d[5:4];
                msb_next_d = 1'b0;
                latched_d  = 1'b0;
            end else if (!latched_d) begin
                latch_d   = counter;
                latched_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk21m) begin
        if (!reset_n) begin
            rw_q       <= 2'b11;
            msb_next_q <= 1'b0;
            latched_q  <= 1'b0;
            latch_q    <= 16'h0000;
            q_q        <= 8'hFF;
            q_update_q <= 1'b0;
            rd_dly_q   <= 1'b0;
        end else begin
            rw_q       <= rw_d;
            msb_next_q <= msb_next_d;
            latched_q  <= latched_d;
            latch_q    <= latch_d;
            q_q        <= q_d;
            q_update_q <= q_update_d;
            rd_dly_q   <= rd_hit;
        end
    end

    assign q        = q_q;
    assign q_update = q_update_q;

endmodule

// File: tb/tb_i8253_readback.sv
// Bench for i8253_readback: directed scenarios plus random traffic, every
// cycle compared against a byte-level model of the channel's read side.
module tb_i8253_readback;

    localparam logic [1:0] ID = 2'd2;

    logic        clk21m = 1'b0;
    logic        reset_n;
    logic        cs, rd, wr_cw;
    logic [1:0]  a;
    logic [7:0]  wr_d;
    logic [15:0] counter;
    logic [7:0]  q;
    logic        q_update;

    int checks   = 0;
    int failures = 0;

    // Model: access mode, "next byte is the high one" toggle, optional held snapshot
    int          m_mode;      // 1=LSB only, 2=MSB only, 3=LSB then MSB
    bit          m_hi_next;
    bit          m_have_snap;
    logic [15:0] m_snap;
    logic [7:0]  m_q;
    bit          m_upd;
    bit          m_was_hit;

    i8253_readback #(.COUNTER_ID(ID)) dut (
        .clk21m  (clk21m),
        .reset_n (reset_n),
        .cs      (cs),
        .rd      (rd),
        .a       (a),
        .wr_cw   (wr_cw),
        .wr_d    (wr_d),
        .counter (counter),
        .q       (q),
        .q_update(q_update)
    );

    always #5 clk21m = ~clk21m;

    function automatic logic [7:0] cwb(input logic [1:0] rwv);
        cwb = {ID, rwv, 4'b0000};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from the inputs presented, then compare.
    task automatic step();
        bit          hit, first;
        bit          take_hi, frees;
        logic [15:0] value;
        int          cw_mode;
        hit   = cs && rd && (a == ID);
        first = hit && !m_was_hit;
        if (!reset_n) begin
            m_mode = 3; m_hi_next = 0; m_have_snap = 0; m_snap = 16'h0000;
            m_q = 8'hFF; m_upd = 0; m_was_hit = 0;
        end else begin
            m_upd = first;
            if (first) begin
                value   = m_have_snap ? m_snap : counter;
                take_hi = (m_mode == 2) || (m_mode == 3 && m_hi_next);
                frees   = (m_mode != 3) || m_hi_next;
                m_q     = take_hi ? value[15:8] : value[7:0];
                if (m_mode == 3) m_hi_next = !m_hi_next;
                if (frees) m_have_snap = 0;
            end
            if (wr_cw && wr_d[7:6] == ID) begin
                cw_mode = int'(wr_d[5:4]);
                if (cw_mode != 0) begin
                    m_mode = cw_mode; m_hi_next = 0; m_have_snap = 0;
                end else if (!m_have_snap) begin
                    m_snap = counter; m_have_snap = 1;
                end
            end
            m_was_hit = hit;
        end
        @(posedge clk21m);
        #1;
        check("q_model", {8'h00, q}, {8'h00, m_q});
        check("q_update_model", {15'h0, q_update}, {15'h0, m_upd});
    endtask

    task automatic idle(input int n);
        cs = 0; rd = 0; a = 2'd0; wr_cw = 0; wr_d = 8'h00;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cw(input logic [7:0] d);
        wr_cw = 1; wr_d = d;
        step();
        wr_cw = 0; wr_d = 8'h00;
    endtask

    // Hold rd for n cycles; returns the number of q_update pulses seen.
    task automatic do_read(input int n, output int pulses);
        pulses = 0;
        cs = 1; rd = 1; a = ID;
        for (int i = 0; i < n; i++) begin
            step();
            if (q_update) pulses++;
        end
        cs = 0; rd = 0; a = 2'd0;
        step();
    endtask

    initial begin
        int p;
        reset_n = 0; cs = 0; rd = 0; a = 0; wr_cw = 0; wr_d = 0; counter = 16'hBEEF;
        m_mode = 3; m_hi_next = 0; m_have_snap = 0; m_snap = 0;
        m_q = 8'hFF; m_upd = 0; m_was_hit = 0;

        // 1: reset, then default LSB-then-MSB read returns LSB
        for (int i = 0; i < 3; i++) step();
        check("reset_q", {8'h00, q}, 16'h00FF);
        check("reset_q_update", {15'h0, q_update}, 16'h0000);
        reset_n = 1;
        idle(1);
        do_read(1, p);
        check("t1_first_lsb", {8'h00, q}, 16'h00EF);

        // 2: LSB-only, long read gives one pulse
        cw(cwb(2'b01));
        counter = 16'h1234;
        do_read(5, p);
        check("t2_pulses", 16'(p), 16'd1);
        check("t2_q", {8'h00, q}, 16'h0034);
        do_read(2, p);
        check("t2_q_again", {8'h00, q}, 16'h0034);

        // 3: MSB-only
        cw(cwb(2'b10));
        counter = 16'hABCD;
        do_read(1, p);
        check("t3_q", {8'h00, q}, 16'h00AB);

        // 4: first latch holds against a second latch command
        cw(cwb(2'b11));
        counter = 16'h1234;
        cw(cwb(2'b00));
        counter = 16'h5678;
        cw(cwb(2'b00));
        do_read(1, p);
        check("t4_lsb", {8'h00, q}, 16'h0034);
        do_read(1, p);
        check("t4_msb", {8'h00, q}, 16'h0012);
        do_read(1, p);
        check("t4_live_lsb", {8'h00, q}, 16'h0078);
        do_read(1, p);

        // 5: mode write clears the MSB-next toggle
        counter = 16'h9A5C;
        do_read(1, p);
        cw(cwb(2'b11));
        do_read(1, p);
        check("t5_lsb_again", {8'h00, q}, 16'h005C);
        do_read(1, p);

        // 6: latch command in the same cycle as the releasing MSB read
        counter = 16'h1234;
        cw(cwb(2'b00));
        do_read(1, p);
        check("t6_lsb", {8'h00, q}, 16'h0034);
        counter = 16'h5678;
        cs = 1; rd = 1; a = ID; wr_cw = 1; wr_d = cwb(2'b00);
        step();
        cs = 0; rd = 0; wr_cw = 0; wr_d = 8'h00;
        step();
        check("t6_old_msb", {8'h00, q}, 16'h0012);
        counter = 16'h0000;
        do_read(1, p);
        check("t6_new_lsb", {8'h00, q}, 16'h0078);
        do_read(1, p);
        check("t6_new_msb", {8'h00, q}, 16'h0056);

        // 6b: reset between LSB and MSB restarts at LSB
        counter = 16'hC3D4;
        do_read(1, p);
        reset_n = 0;
        do_read(2, p);
        check("t6_reset_q", {8'h00, q}, 16'h00FF);
        reset_n = 1;
        do_read(1, p);
        check("t6_after_reset_lsb", {8'h00, q}, 16'h00D4);

        // Wrong address / no chip select must not read
        cs = 1; rd = 1; a = 2'd1; step(); step();
        cs = 0; a = ID; step();
        idle(1);
        check("no_hit_q", {8'h00, q}, 16'h00D4);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            cs      = ($urandom_range(0, 3) != 0);
            rd      = ($urandom_range(0, 2) != 0);
            a       = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : ID;
            wr_cw   = ($urandom_range(0, 5) == 0);
            wr_d    = ($urandom_range(0, 2) == 0) ? 8'($urandom) : {ID, 2'($urandom_range(0, 3)), 4'($urandom)};
            if ($urandom_range(0, 2) == 0) counter = 16'($urandom);
            step();
        end
        reset_n = 1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
